// File: rtl/ql_sync_fifo.sv
// Single-clock synchronous FIFO cell model: configurable width/depth, count-decoded
// threshold flags, and standard (registered) or first-word-fall-through read port.
module ql_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter bit FWFT       = 1'b0,
  parameter int AE_THRESH  = 4,
  parameter int AF_THRESH  = 4
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  FFLUSH,
  input  logic                  WEN,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  REN,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int AF_LEVEL_I = DEPTH - AF_THRESH;

  localparam logic [ADDR_WIDTH:0] DEPTH_C    = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LEVEL_C = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LEVEL_C = AF_LEVEL_I[ADDR_WIDTH:0];

  if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_data_width
    $error("ql_sync_fifo: DATA_WIDTH %0d outside 1..64", DATA_WIDTH);
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 15) begin : g_bad_addr_width
    $error("ql_sync_fifo: ADDR_WIDTH %0d outside 1..15", ADDR_WIDTH);
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae_thresh
    $error("ql_sync_fifo: AE_THRESH %0d outside 0..DEPTH-1", AE_THRESH);
  end
  if (AF_THRESH < 0 || AF_THRESH >= DEPTH) begin : g_bad_af_thresh
    $error("ql_sync_fifo: AF_THRESH %0d outside 0..DEPTH-1", AF_THRESH);
  end

  // Request/accept contract: WEN and REN are requests sampled at posedge CLK.
  // A write is accepted iff WEN && !FULL, a read iff REN && !EMPTY, with both
  // flags taken from the registered COUNT before the edge. A rejected request
  // is dropped and answered by a one-cycle OVERFLOW/UNDERFLOW pulse; there is
  // no back-pressure beyond the flags themselves.

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic empty_w;
  logic full_w;
  logic wr_ok;
  logic rd_ok;
  logic mem_we;
  logic pop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  assign wr_ok = WEN && !full_w;
  assign rd_ok = REN && !empty_w;

  // Flush wins over any same-cycle traffic, so no write lands and no pop occurs.
  assign mem_we = wr_ok && !FFLUSH && !CLR;
  assign pop    = rd_ok && !FFLUSH && !CLR;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (FFLUSH) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_ok) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      ovf_d = WEN && full_w;
      unf_d = REN && empty_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[wptr_q] <= WDATA;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented combinationally from the stored array.
    assign RDATA = mem_q[rptr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge CLK) begin
      if (CLR) begin
        rdata_q <= '0;
      end else if (pop) begin
        rdata_q <= mem_q[rptr_q];
      end
    end

    assign RDATA = rdata_q;
  end

  assign COUNT        = count_q;
  assign EMPTY        = empty_w;
  assign FULL         = full_w;
  assign ALMOST_EMPTY = (count_q <= AE_LEVEL_C);
  assign ALMOST_FULL  = (count_q >= AF_LEVEL_C);
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_ql_sync_fifo.sv
// Directed bench for ql_sync_fifo: one standard-read and one FWFT instance,
// both 8 bits wide and 4 deep, with thresholds AE=1 and AF=1.
module tb_ql_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-read instance
  logic       s_clr, s_ffl, s_wen, s_ren;
  logic [7:0] s_wdata, s_rdata;
  logic [2:0] s_count;
  logic       s_empty, s_full, s_ae, s_af, s_ovf, s_unf;

  // FWFT instance
  logic       f_clr, f_ffl, f_wen, f_ren;
  logic [7:0] f_wdata, f_rdata;
  logic [2:0] f_count;
  logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [7:0] exp_q[$];

  ql_sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1'b0), .AE_THRESH(1), .AF_THRESH(1)
  ) u_std (
    .CLK(clk), .CLR(s_clr), .FFLUSH(s_ffl), .WEN(s_wen), .WDATA(s_wdata),
    .REN(s_ren), .RDATA(s_rdata), .COUNT(s_count), .EMPTY(s_empty),
    .FULL(s_full), .ALMOST_EMPTY(s_ae), .ALMOST_FULL(s_af),
    .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
  );

  ql_sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1'b1), .AE_THRESH(1), .AF_THRESH(1)
  ) u_fwft (
    .CLK(clk), .CLR(f_clr), .FFLUSH(f_ffl), .WEN(f_wen), .WDATA(f_wdata),
    .REN(f_ren), .RDATA(f_rdata), .COUNT(f_count), .EMPTY(f_empty),
    .FULL(f_full), .ALMOST_EMPTY(f_ae), .ALMOST_FULL(f_af),
    .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Standard instance status: count, empty, full, almost_empty, almost_full
  task automatic check_std_flags(input string tag, input int cnt, input logic e,
                                 input logic f, input logic ae, input logic af);
    check({tag, ".count"}, 16'(s_count), 16'(cnt));
    check({tag, ".empty"}, 16'(s_empty), 16'(e));
    check({tag, ".full"},  16'(s_full),  16'(f));
    check({tag, ".ae"},    16'(s_ae),    16'(ae));
    check({tag, ".af"},    16'(s_af),    16'(af));
  endtask

  task automatic std_write(input logic [7:0] d);
    s_wen   = 1'b1;
    s_wdata = d;
    tick();
    s_wen   = 1'b0;
  endtask

  task automatic fwft_write(input logic [7:0] d);
    f_wen   = 1'b1;
    f_wdata = d;
    tick();
    f_wen   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    s_clr = 1'b1; s_ffl = 1'b0; s_wen = 1'b0; s_ren = 1'b0; s_wdata = 8'h00;
    f_clr = 1'b1; f_ffl = 1'b0; f_wen = 1'b0; f_ren = 1'b0; f_wdata = 8'h00;

    // Reset
    tick();
    s_clr = 1'b0;
    f_clr = 1'b0;
    check_std_flags("reset", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("reset.rdata", 16'(s_rdata), 16'h0000);
    check("reset.ovf",   16'(s_ovf),   16'd0);
    check("reset.unf",   16'(s_unf),   16'd0);
    check("reset.f_count", 16'(f_count), 16'd0);
    check("reset.f_empty", 16'(f_empty), 16'd1);

    // Write and read into empty FIFO together: read is rejected, write lands
    s_wen = 1'b1; s_ren = 1'b1; s_wdata = 8'hA1;
    tick();
    s_wen = 1'b0; s_ren = 1'b0;
    check("wr_rd_empty.unf",   16'(s_unf),   16'd1);
    check("wr_rd_empty.rdata", 16'(s_rdata), 16'h0000);
    check_std_flags("fill1", 1, 1'b0, 1'b0, 1'b1, 1'b0);

    std_write(8'hA2);
    check("fill2.unf", 16'(s_unf), 16'd0);
    check_std_flags("fill2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    std_write(8'hA3);
    check_std_flags("fill3", 3, 1'b0, 1'b0, 1'b0, 1'b1);
    std_write(8'hA4);
    check_std_flags("fill4", 4, 1'b0, 1'b1, 1'b0, 1'b1);

    // Overflow pulses, repeating while the request persists
    s_wen = 1'b1; s_wdata = 8'hA5;
    tick();
    check("ovf1.ovf",   16'(s_ovf),   16'd1);
    check("ovf1.count", 16'(s_count), 16'd4);
    tick();
    check("ovf2.ovf",   16'(s_ovf),   16'd1);
    s_wen = 1'b0;
    tick();
    check("ovf_end.ovf",   16'(s_ovf),   16'd0);
    check("ovf_end.count", 16'(s_count), 16'd4);

    // Drain in standard mode: each word appears one cycle after its REN
    s_ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain.rdata", 16'(s_rdata), 16'(8'hA1 + i));
      check("drain.count", 16'(s_count), 16'(3 - i));
    end
    check("drain.empty", 16'(s_empty), 16'd1);
    check("drain.ae",    16'(s_ae),    16'd1);
    tick();
    check("unf.unf",   16'(s_unf),   16'd1);
    check("unf.rdata", 16'(s_rdata), 16'h00A4);
    check("unf.count", 16'(s_count), 16'd0);
    s_ren = 1'b0;
    tick();
    check("unf_end.unf", 16'(s_unf), 16'd0);

    // Wrap-around with simultaneous read/write at COUNT=1
    std_write(8'h31);
    std_write(8'h32);
    std_write(8'h33);
    s_ren = 1'b1;
    tick();
    check("pre_wrap.rdata", 16'(s_rdata), 16'h0031);
    tick();
    check("pre_wrap.rdata", 16'(s_rdata), 16'h0032);
    check("pre_wrap.count", 16'(s_count), 16'd1);
    exp_q.push_back(8'h33);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
    s_wen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_wdata = 8'h10 + 8'(i);
      tick();
      check("wrap.rdata", 16'(s_rdata), 16'(exp_q.pop_front()));
      check("wrap.count", 16'(s_count), 16'd1);
    end
    s_wen = 1'b0; s_ren = 1'b0;

    // Flush with COUNT=3 and both requests active
    std_write(8'h21);
    std_write(8'h22);
    check("pre_flush.count", 16'(s_count), 16'd3);
    s_ffl = 1'b1; s_wen = 1'b1; s_ren = 1'b1; s_wdata = 8'h99;
    tick();
    s_ffl = 1'b0; s_wen = 1'b0; s_ren = 1'b0;
    check_std_flags("flush", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush.ovf",   16'(s_ovf),   16'd0);
    check("flush.unf",   16'(s_unf),   16'd0);
    check("flush.rdata", 16'(s_rdata), 16'h0014);
    std_write(8'h77);
    s_ren = 1'b1;
    tick();
    s_ren = 1'b0;
    check("post_flush.rdata", 16'(s_rdata), 16'h0077);
    check("post_flush.count", 16'(s_count), 16'd0);

    // Reset while full, with requests active
    std_write(8'hC1);
    std_write(8'hC2);
    std_write(8'hC3);
    std_write(8'hC4);
    check("pre_clr.full", 16'(s_full), 16'd1);
    s_clr = 1'b1; s_wen = 1'b1; s_ren = 1'b1; s_wdata = 8'hEE;
    tick();
    s_clr = 1'b0; s_wen = 1'b0; s_ren = 1'b0;
    check_std_flags("clr_full", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("clr_full.rdata", 16'(s_rdata), 16'h0000);
    check("clr_full.ovf",   16'(s_ovf),   16'd0);
    check("clr_full.unf",   16'(s_unf),   16'd0);

    // FWFT: head word visible without REN
    fwft_write(8'h5C);
    check("fwft.empty", 16'(f_empty), 16'd0);
    check("fwft.rdata", 16'(f_rdata), 16'h005C);
    tick();
    check("fwft_hold.rdata", 16'(f_rdata), 16'h005C);
    f_ren = 1'b1;
    tick();
    f_ren = 1'b0;
    check("fwft_pop.empty", 16'(f_empty), 16'd1);
    check("fwft_pop.count", 16'(f_count), 16'd0);
    fwft_write(8'h61);
    fwft_write(8'h62);
    check("fwft_two.rdata", 16'(f_rdata), 16'h0061);
    check("fwft_two.count", 16'(f_count), 16'd2);
    f_ren = 1'b1;
    tick();
    check("fwft_next.rdata", 16'(f_rdata), 16'h0062);
    check("fwft_next.count", 16'(f_count), 16'd1);
    tick();
    f_ren = 1'b0;
    check("fwft_last.empty", 16'(f_empty), 16'd1);
    check("fwft_last.unf",   16'(f_unf),   16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
